// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline MEM stage.
package mips_pipe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  localparam int          REG_ADDR_W = 5;
  localparam logic [31:0] POISON     = 32'hDEADBEEF;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for an outstanding data-memory access.
// Clear has priority over enable; tc_o flags the last allowed wait cycle.
module mem_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory req/ack access, hazard stall and MEM/WB register bank.
// Optional access timeout with sticky error is enabled by defining MEM_TIMEOUT_EN.
module mem_stage
  import mips_pipe_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EXMEM_M2R,
  input  logic                  EXMEM_RegWr,
  input  logic [AW-1:0]         EXMEM_aluout,
  input  logic [DW-1:0]         MEMData,
  input  logic [REG_ADDR_W-1:0] EXMEM_Rd,
  input  logic                  MemWr,
  input  logic                  MemR,
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [AW-1:0]         dm_addr,
  output logic [DW-1:0]         dm_wdata,
  input  logic                  dm_ack,
  input  logic [DW-1:0]         dm_rdata,
  output logic                  stall,
  output logic                  MEMWB_RegWr,
  output logic                  MEMWB_M2R,
  output logic [DW-1:0]         MEMWB_aluout,
  output logic [DW-1:0]         MEMWB_rdata,
  output logic [REG_ADDR_W-1:0] MEMWB_Rd,
  output logic                  mem_err
);

  mem_state_e state_q;

  logic acc, is_load, tout, stall_int;

  logic                  regwr_q, regwr_d;
  logic                  m2r_q, m2r_d;
  logic [DW-1:0]         alu_q, alu_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  err_q, err_d;

  // A combined load+store is executed as a store only.
  assign acc     = MemR | MemWr;
  assign is_load = MemR & ~MemWr;

`ifdef MEM_TIMEOUT_EN
  logic tc;

  mem_wait_timer #(.LIMIT(TIMEOUT_CYC)) u_wait_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == IDLE),
    .en_i  (state_q == BUSY),
    .tc_o  (tc)
  );

  assign tout = (state_q == BUSY) & acc & ~dm_ack & tc;
`else
  // No wait limit: the access stays pending until the memory acknowledges.
  assign tout = 1'b0 & (TIMEOUT_CYC > 0);
`endif

  assign stall_int = acc & ~dm_ack & ~tout;

  // Request and stall drop as soon as reset asserts, mid-access included.
  assign dm_req   = acc & ~rst;
  assign dm_we    = MemWr;
  assign dm_addr  = EXMEM_aluout;
  assign dm_wdata = MEMData;
  assign stall    = stall_int & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (acc && !dm_ack) state_q <= BUSY;
        BUSY:    if (dm_ack || tout || !acc) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stalled edges insert a bubble so WB never commits the same instruction twice.
  always_comb begin
    regwr_d = regwr_q;
    m2r_d   = m2r_q;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    err_d   = err_q;
    if (stall_int) begin
      regwr_d = 1'b0;
    end else begin
      regwr_d = EXMEM_RegWr & ~tout;
      m2r_d   = EXMEM_M2R;
      alu_d   = DW'(EXMEM_aluout);
      rd_d    = EXMEM_Rd;
      if (tout) begin
        rdata_d = DW'(POISON);
        err_d   = 1'b1;
      end else if (is_load) begin
        rdata_d = dm_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwr_q <= 1'b0;
      m2r_q   <= 1'b0;
      alu_q   <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      regwr_q <= regwr_d;
      m2r_q   <= m2r_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  assign MEMWB_RegWr  = regwr_q;
  assign MEMWB_M2R    = m2r_q;
  assign MEMWB_aluout = alu_q;
  assign MEMWB_rdata  = rdata_q;
  assign MEMWB_Rd     = rd_q;
  assign mem_err      = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage; timeout steps run when MEM_TIMEOUT_EN is defined.
module tb_mem_stage;
  import mips_pipe_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          EXMEM_M2R, EXMEM_RegWr, MemWr, MemR, dm_ack;
  logic [AW-1:0] EXMEM_aluout;
  logic [DW-1:0] MEMData, dm_rdata;
  logic [4:0]    EXMEM_Rd;
  logic          dm_req, dm_we, stall, MEMWB_RegWr, MEMWB_M2R, mem_err;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, MEMWB_aluout, MEMWB_rdata;
  logic [4:0]    MEMWB_Rd;

  always #5 clk = ~clk;

  mem_stage #(.AW(AW), .DW(DW), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .EXMEM_M2R(EXMEM_M2R), .EXMEM_RegWr(EXMEM_RegWr), .EXMEM_aluout(EXMEM_aluout),
    .MEMData(MEMData), .EXMEM_Rd(EXMEM_Rd), .MemWr(MemWr), .MemR(MemR),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall(stall),
    .MEMWB_RegWr(MEMWB_RegWr), .MEMWB_M2R(MEMWB_M2R), .MEMWB_aluout(MEMWB_aluout),
    .MEMWB_rdata(MEMWB_rdata), .MEMWB_Rd(MEMWB_Rd), .mem_err(mem_err)
  );

  typedef struct packed {
    logic        regwr;
    logic        m2r;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
  } wb_t;

  wb_t  sb[$];
  wb_t  mdl;
  logic exp_err;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    MemR = 0; MemWr = 0; dm_ack = 0; EXMEM_RegWr = 0; EXMEM_M2R = 0;
    EXMEM_aluout = '0; MEMData = '0; dm_rdata = '0; EXMEM_Rd = '0;
  endtask

  // One clock cycle: drive, check the bus side, predict MEM/WB, then check after the edge.
  task automatic cyc(input string tag, input logic r, input logic w, input logic a,
                     input logic rw, input logic m2r, input logic [31:0] alu,
                     input logic [31:0] wd, input logic [31:0] rdat, input logic [4:0] rd,
                     input logic tout);
    wb_t n, e;
    MemR = r; MemWr = w; dm_ack = a; EXMEM_RegWr = rw; EXMEM_M2R = m2r;
    EXMEM_aluout = alu; MEMData = wd; dm_rdata = rdat; EXMEM_Rd = rd;
    #1;
    chk({tag, ".req"},   {31'd0, dm_req}, {31'd0, r | w});
    chk({tag, ".we"},    {31'd0, dm_we},  {31'd0, w});
    chk({tag, ".stall"}, {31'd0, stall},  {31'd0, (r | w) & ~a & ~tout});
    chk({tag, ".addr"},  dm_addr,  alu);
    chk({tag, ".wdata"}, dm_wdata, wd);
    n = mdl;
    if (tout) begin
      n.regwr = 1'b0; n.m2r = m2r; n.alu = alu; n.rd = rd; n.rdata = 32'hDEADBEEF;
      exp_err = 1'b1;
    end else if ((r | w) && !a) begin
      n.regwr = 1'b0;
    end else begin
      n.regwr = rw; n.m2r = m2r; n.alu = alu; n.rd = rd;
      if (r && !w) n.rdata = rdat;
    end
    sb.push_back(n);
    mdl = n;
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({tag, ".wb_regwr"}, {31'd0, MEMWB_RegWr}, {31'd0, e.regwr});
    chk({tag, ".wb_m2r"},   {31'd0, MEMWB_M2R},   {31'd0, e.m2r});
    chk({tag, ".wb_alu"},   MEMWB_aluout, e.alu);
    chk({tag, ".wb_rdata"}, MEMWB_rdata,  e.rdata);
    chk({tag, ".wb_rd"},    {27'd0, MEMWB_Rd}, {27'd0, e.rd});
    chk({tag, ".err"},      {31'd0, mem_err},  {31'd0, exp_err});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".req"},      {31'd0, dm_req},      32'd0);
    chk({tag, ".stall"},    {31'd0, stall},       32'd0);
    chk({tag, ".wb_regwr"}, {31'd0, MEMWB_RegWr}, 32'd0);
    chk({tag, ".wb_m2r"},   {31'd0, MEMWB_M2R},   32'd0);
    chk({tag, ".wb_alu"},   MEMWB_aluout,         32'd0);
    chk({tag, ".wb_rdata"}, MEMWB_rdata,          32'd0);
    chk({tag, ".wb_rd"},    {27'd0, MEMWB_Rd},    32'd0);
    chk({tag, ".err"},      {31'd0, mem_err},     32'd0);
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    mdl = '0;
    exp_err = 1'b0;
    #3;
    chk_reset_state("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero-wait load
    cyc("ld0", 1, 0, 1, 1, 1, 32'h10, 32'h0, 32'h1234, 5'd3, 0);

    // Store with three-cycle access
    cyc("st_w1", 0, 1, 0, 0, 0, 32'h20, 32'hCAFE, 32'h0, 5'd0, 0);
    cyc("st_w2", 0, 1, 0, 0, 0, 32'h20, 32'hCAFE, 32'h0, 5'd0, 0);
    cyc("st_ak", 0, 1, 1, 0, 0, 32'h20, 32'hCAFE, 32'h0, 5'd0, 0);

    // Load with two wait cycles; rdata is junk until ack
    cyc("ld2_w1", 1, 0, 0, 1, 1, 32'h30, 32'h0, 32'hBAD0, 5'd9, 0);
    cyc("ld2_w2", 1, 0, 0, 1, 1, 32'h30, 32'h0, 32'hBAD1, 5'd9, 0);
    cyc("ld2_ak", 1, 0, 1, 1, 1, 32'h30, 32'h0, 32'h55AA, 5'd9, 0);

    // Back-to-back: load acked, then combined load+store treated as store
    cyc("b2b_ld", 1, 0, 1, 1, 1, 32'h34, 32'h0, 32'h7777, 5'd12, 0);
    cyc("b2b_rw", 1, 1, 1, 0, 0, 32'h38, 32'hBEEF, 32'h9999, 5'd13, 0);

    // Non-memory ALU op, and a stray ack with no access
    cyc("alu",   0, 0, 0, 1, 0, 32'hABCD, 32'h0, 32'h0, 5'd17, 0);
    cyc("stray", 0, 0, 1, 1, 0, 32'h1111, 32'h0, 32'hFFFF, 5'd18, 0);

    // Asynchronous reset while an access is outstanding
    cyc("rb_w", 1, 0, 0, 1, 1, 32'h40, 32'h0, 32'h0, 5'd7, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state("rst_busy");
    set_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    mdl = '0;
    exp_err = 1'b0;
    cyc("post_rst", 1, 0, 1, 1, 1, 32'h44, 32'h0, 32'h4242, 5'd21, 0);

`ifdef MEM_TIMEOUT_EN
    // No ack: four stalled cycles, then forced poisoned completion
    for (int i = 0; i < 4; i++)
      cyc("to_wait", 1, 0, 0, 1, 1, 32'h80, 32'h0, 32'h1111, 5'd22, 0);
    cyc("to_fire", 1, 0, 0, 1, 1, 32'h80, 32'h0, 32'h1111, 5'd22, 1);
    cyc("to_sticky", 0, 0, 0, 1, 0, 32'h5, 32'h0, 32'h0, 5'd23, 0);
    rst = 1'b1;
    #1;
    chk_reset_state("to_rst");
    @(posedge clk); #1;
    rst = 1'b0;
`else
    // Without a timeout the access waits as long as the memory does
    for (int i = 0; i < 6; i++)
      cyc("long_wait", 1, 0, 0, 1, 1, 32'h80, 32'h0, 32'h1111, 5'd22, 0);
    cyc("long_ack", 1, 0, 1, 1, 1, 32'h80, 32'h0, 32'h2222, 5'd22, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
